iob_cache_line_fill_buffer: RTL and testbench
=============================================

# iob_cache_line_fill_buffer

Line-fill buffer sitting directly downstream of the AXI read channel in the cache back-end. It accepts a read-miss request from the cache control, issues the replace request to the read channel, assembles the returned back-end beats into one full cache line, and commits that line to the data memory in a single write cycle. It also returns the missed word to the front-end.

## Interface
Parameters:
- ADDR_W, 32: front-end byte address width.
- DATA_W, 32: front-end word width.
- BE_DATA_W, 32: back-end beat width; a multiple of DATA_W.
- WORD_OFFSET_W, 3: log2 of front-end words per line.
- BE_NBYTES_W, derived: $clog2(BE_DATA_W/8).
- LINE2BE_W, derived: WORD_OFFSET_W - $clog2(BE_DATA_W/DATA_W); the number of beats per line is 2**LINE2BE_W.
- LINE_W, derived: BE_DATA_W * 2**LINE2BE_W.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, **synchronous, active-low**.
- miss_valid_i  in  1  read-miss request.
- miss_addr_i  in  ADDR_W-$clog2(DATA_W/8)  missed word address.
- miss_ready_o  out  1  request accepted; high only in IDLE.
- replace_valid_o  out  1  to read channel replace_valid_i.
- replace_addr_o  out  ADDR_W-(BE_NBYTES_W+LINE2BE_W)  line address.
- replace_i  in  1  read channel busy (its replace_o).
- read_valid_i  in  1  beat valid.
- read_addr_i  in  max(LINE2BE_W,1)  beat index in line.
- read_rdata_i  in  BE_DATA_W  beat data.
- line_we_o  out  1  one-cycle line write strobe.
- line_addr_o  out  ADDR_W-(BE_NBYTES_W+LINE2BE_W)  line address being written.
- line_wdata_o  out  LINE_W  assembled line; beat k occupies bits [k*BE_DATA_W +: BE_DATA_W].
- crit_valid_o  out  1  one-cycle pulse that returns the missed word.
- crit_rdata_o  out  DATA_W  missed word.
- fill_err_o  out  1  one-cycle pulse: fill ended with a missing beat.

## Operation
- The FSM has four states: IDLE, REQ, FILL and COMMIT.
- **IDLE:** miss_ready_o=1.
  - On miss_valid_i, register miss_addr_i.
  - Clear the beat valid mask (one bit per beat).
  - Go to REQ.
- **REQ:**
  - Drive replace_valid_o=1 and replace_addr_o = registered line address.
  - Hold both until replace_i=1 is sampled, then go to FILL.
- **FILL:**
  - Each read_valid_i writes buf[read_addr_i] and sets mask[read_addr_i].
  - A repeated index overwrites the earlier data. This covers a read-channel retry after a slave error.
  - When replace_i=0 is sampled, go to COMMIT.
- **COMMIT:** lasts one cycle, then the FSM returns to IDLE.
  - If the mask is all ones, pulse line_we_o=1 with line_wdata_o=buf and line_addr_o.
  - Otherwise pulse fill_err_o=1 and do not raise line_we_o.
- **Critical word:** beat index = miss word offset >> $clog2(BE_DATA_W/DATA_W). The word within the beat is selected by the low offset bits.
- **LINE2BE_W=0:** one beat per line and read_addr_i is ignored. In FILL, any read_valid_i writes buf[0].

## Timing
- **Reset values:** state=IDLE, mask=0, and all outputs 0 except miss_ready_o=1. Buffer data is not reset.
- Reset asserted mid-fill returns the FSM to IDLE on the next edge. No line_we_o or crit_valid_o is produced for the aborted fill.
- miss_valid_i accepted in cycle N → replace_valid_o=1 in cycle N+1.
- The beat on the cycle when replace_i is first sampled 1 is not expected.
- read_valid_i outside FILL is ignored.
- replace_i falls after the read channel's end-process cycle, so the last beat always precedes COMMIT.
- line_we_o is asserted exactly one cycle after replace_i=0 is sampled in FILL.
- miss_valid_i while not in IDLE is not accepted; miss_ready_o=0.

## Configuration
- **IOB_CACHE_LFB_CRIT_WORD_EN defined:**
  - crit_valid_o pulses in the cycle after the first FILL beat whose index equals the critical beat index.
  - A later retry of that beat does not produce a second pulse.
- **IOB_CACHE_LFB_CRIT_WORD_EN undefined:**
  - crit_valid_o pulses in the COMMIT cycle, together with line_we_o, with data taken from buf.
  - On fill_err_o there is no crit pulse.

## Structure
- Shared package `iob_cache_lfb_pkg`:
  - FSM state encodings (IDLE=0, REQ=1, FILL=2, COMMIT=3).
  - A line-width helper constant function.
- One sub-module, `iob_cache_lfb_word_sel`: a combinational selector that extracts the DATA_W critical word from a beat or line given the word offset. It is used by both configuration variants.

## Test plan
Default parameters: 4 beats of 64 bits, DATA_W=32.
- **In-order fill:**
  - Stimulus: miss word addr 0x1005, beats 0..3 = 0xA0..0xA3 patterns.
  - Required response: line_we_o one cycle after replace_i falls; line_wdata_o holds the beats in order; crit_rdata_o = upper half of beat 2.
- **Retry:**
  - Stimulus: beats 0..3, then a repeat of 0..3 with new data before replace_i falls.
  - Required response: the committed line contains the second data set; exactly one crit_valid_o.
- **Missing beat:**
  - Stimulus: beats 0, 1 and 3 only, then replace_i=0.
  - Required response: fill_err_o=1 and line_we_o stays 0.
- **Back-pressure:**
  - Stimulus: replace_i held 0 for 5 cycles in REQ.
  - Required response: replace_valid_o and replace_addr_o remain stable; miss_ready_o=0.
- **Mid-fill reset:**
  - Stimulus: reset_n_i=0 after beat 1.
  - Required response: next cycle IDLE, miss_ready_o=1, no line_we_o or crit_valid_o.
- **Macro toggle:** rerun the in-order fill with and without IOB_CACHE_LFB_CRIT_WORD_EN.
  - Defined: crit_valid_o one cycle after beat 2.
  - Undefined: crit_valid_o in the COMMIT cycle.

Source files
------------

// File: rtl/iob_cache_lfb_pkg.sv
// Shared types and helpers for the cache line-fill buffer.
package iob_cache_lfb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } lfb_state_t;

  // Full line width: one back-end beat times the number of beats per line.
  function automatic int lfb_line_w(input int be_data_w, input int data_w,
                                    input int word_offset_w);
    return be_data_w * (2 ** (word_offset_w - $clog2(be_data_w / data_w)));
  endfunction

  function automatic int lfb_max1(input int v);
    return (v > 1) ? v : 1;
  endfunction

endpackage

// File: rtl/iob_cache_line_fill_buffer_if.sv
// Miss request, read-channel and line-write signals of the line-fill buffer.
interface iob_cache_line_fill_buffer_if #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int BE_DATA_W     = 32,
  parameter int WORD_OFFSET_W = 3
);
  import iob_cache_lfb_pkg::*;

  localparam int BE_NBYTES_W = $clog2(BE_DATA_W / 8);
  localparam int LINE2BE_W   = WORD_OFFSET_W - $clog2(BE_DATA_W / DATA_W);
  localparam int LINE_W      = lfb_line_w(BE_DATA_W, DATA_W, WORD_OFFSET_W);
  localparam int MISS_ADDR_W = ADDR_W - $clog2(DATA_W / 8);
  localparam int LINE_ADDR_W = ADDR_W - (BE_NBYTES_W + LINE2BE_W);
  localparam int IDX_W       = lfb_max1(LINE2BE_W);

  logic                   miss_valid_i;
  logic [MISS_ADDR_W-1:0] miss_addr_i;
  logic                   miss_ready_o;
  logic                   replace_valid_o;
  logic [LINE_ADDR_W-1:0] replace_addr_o;
  logic                   replace_i;
  logic                   read_valid_i;
  logic [IDX_W-1:0]       read_addr_i;
  logic [BE_DATA_W-1:0]   read_rdata_i;
  logic                   line_we_o;
  logic [LINE_ADDR_W-1:0] line_addr_o;
  logic [LINE_W-1:0]      line_wdata_o;
  logic                   crit_valid_o;
  logic [DATA_W-1:0]      crit_rdata_o;
  logic                   fill_err_o;

  modport slave (
    input  miss_valid_i, miss_addr_i, replace_i, read_valid_i, read_addr_i, read_rdata_i,
    output miss_ready_o, replace_valid_o, replace_addr_o, line_we_o, line_addr_o,
           line_wdata_o, crit_valid_o, crit_rdata_o, fill_err_o
  );

  modport master (
    output miss_valid_i, miss_addr_i, replace_i, read_valid_i, read_addr_i, read_rdata_i,
    input  miss_ready_o, replace_valid_o, replace_addr_o, line_we_o, line_addr_o,
           line_wdata_o, crit_valid_o, crit_rdata_o, fill_err_o
  );

endinterface

// File: rtl/iob_cache_lfb_word_sel.sv
// Extracts one DATA_W word from a beat or a full line given its word offset.
module iob_cache_lfb_word_sel #(
  parameter int IN_W   = 64,
  parameter int DATA_W = 32,
  parameter int OFF_W  = 3
) (
  input  logic [IN_W-1:0]   data_i,
  input  logic [OFF_W-1:0]  off_i,
  output logic [DATA_W-1:0] word_o
);

  always_comb begin
    word_o = DATA_W'(data_i >> (int'(off_i) * DATA_W));
  end

endmodule

// File: rtl/iob_cache_line_fill_buffer.sv
// Line-fill buffer: requests a line, assembles beats, commits it in one write.
// IOB_CACHE_LFB_CRIT_WORD_EN returns the missed word as soon as its beat lands.
module iob_cache_line_fill_buffer
  import iob_cache_lfb_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int BE_DATA_W     = 32,
  parameter int WORD_OFFSET_W = 3
) (
  input logic                   clk_i,
  input logic                   reset_n_i,
  iob_cache_line_fill_buffer_if.slave bus
);

  localparam int RATIO_W     = $clog2(BE_DATA_W / DATA_W);
  localparam int LINE2BE_W   = WORD_OFFSET_W - RATIO_W;
  localparam int NBEATS      = 2 ** LINE2BE_W;
  localparam int LINE_W      = lfb_line_w(BE_DATA_W, DATA_W, WORD_OFFSET_W);
  localparam int MISS_ADDR_W = ADDR_W - $clog2(DATA_W / 8);
  localparam int IDX_W       = lfb_max1(LINE2BE_W);
  localparam logic [WORD_OFFSET_W-1:0] LO_MASK = WORD_OFFSET_W'((1 << RATIO_W) - 1);

  lfb_state_t state, state_nxt;

  logic [MISS_ADDR_W-1:0]   miss_addr_q;
  logic [NBEATS-1:0]        mask_q;
  logic [BE_DATA_W-1:0]     beat_q [NBEATS];
  logic [LINE_W-1:0]        line_data;
  logic [WORD_OFFSET_W-1:0] word_off;
  logic [IDX_W-1:0]         crit_beat;
  logic [IDX_W-1:0]         beat_idx;
  logic                     beat_wr;
  logic                     miss_ready;
  logic                     replace_valid;
  logic                     commit_ok;
  logic                     commit_err;
  logic                     crit_valid;
  logic [DATA_W-1:0]        crit_rdata;

  assign word_off  = miss_addr_q[WORD_OFFSET_W-1:0];
  assign crit_beat = IDX_W'(word_off >> RATIO_W);
  assign beat_idx  = (LINE2BE_W == 0) ? '0 : bus.read_addr_i;
  assign beat_wr   = (state == FILL) && bus.read_valid_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    miss_ready    = 1'b0;
    replace_valid = 1'b0;
    commit_ok     = 1'b0;
    commit_err    = 1'b0;
    unique case (state)
      IDLE: begin
        miss_ready = 1'b1;
        if (bus.miss_valid_i) state_nxt = REQ;
      end
      REQ: begin
        replace_valid = 1'b1;
        if (bus.replace_i) state_nxt = FILL;
      end
      FILL: begin
        if (!bus.replace_i) state_nxt = COMMIT;
      end
      COMMIT: begin
        commit_ok  = &mask_q;
        commit_err = ~(&mask_q);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      miss_addr_q <= '0;
      mask_q      <= '0;
    end else begin
      if ((state == IDLE) && bus.miss_valid_i) begin
        miss_addr_q <= bus.miss_addr_i;
        mask_q      <= '0;
      end
      if (beat_wr) mask_q[beat_idx] <= 1'b1;
    end
  end

  // Beat storage carries no reset; the mask alone decides whether it is usable.
  always_ff @(posedge clk_i) begin
    if (beat_wr) beat_q[beat_idx] <= bus.read_rdata_i;
  end

  always_comb begin
    line_data = '0;
    for (int unsigned k = 0; k < NBEATS; k++) begin
      line_data[k*BE_DATA_W +: BE_DATA_W] = beat_q[k];
    end
  end

`ifdef IOB_CACHE_LFB_CRIT_WORD_EN
  logic [DATA_W-1:0] beat_word;
  logic              crit_seen_q;
  logic              crit_valid_q;
  logic [DATA_W-1:0] crit_data_q;

  iob_cache_lfb_word_sel #(
    .IN_W   (BE_DATA_W),
    .DATA_W (DATA_W),
    .OFF_W  (WORD_OFFSET_W)
  ) u_word_sel (
    .data_i (bus.read_rdata_i),
    .off_i  (word_off & LO_MASK),
    .word_o (beat_word)
  );

  // crit_seen_q suppresses a second pulse when the critical beat is retried.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      crit_seen_q  <= 1'b0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      crit_valid_q <= 1'b0;
      if (state == IDLE) crit_seen_q <= 1'b0;
      if (beat_wr && (beat_idx == crit_beat) && !crit_seen_q) begin
        crit_seen_q  <= 1'b1;
        crit_valid_q <= 1'b1;
        crit_data_q  <= beat_word;
      end
    end
  end

  assign crit_valid = crit_valid_q;
  assign crit_rdata = crit_data_q;
`else
  logic [DATA_W-1:0] line_word;

  iob_cache_lfb_word_sel #(
    .IN_W   (LINE_W),
    .DATA_W (DATA_W),
    .OFF_W  (WORD_OFFSET_W)
  ) u_word_sel (
    .data_i (line_data),
    .off_i  (word_off),
    .word_o (line_word)
  );

  assign crit_valid = commit_ok;
  assign crit_rdata = commit_ok ? line_word : '0;
`endif

  assign bus.miss_ready_o    = miss_ready;
  assign bus.replace_valid_o = replace_valid;
  assign bus.replace_addr_o  = miss_addr_q[MISS_ADDR_W-1:WORD_OFFSET_W];
  assign bus.line_we_o       = commit_ok;
  assign bus.line_addr_o     = miss_addr_q[MISS_ADDR_W-1:WORD_OFFSET_W];
  assign bus.line_wdata_o    = commit_ok ? line_data : '0;
  assign bus.fill_err_o      = commit_err;
  assign bus.crit_valid_o    = crit_valid;
  assign bus.crit_rdata_o    = crit_rdata;

endmodule

// File: tb/tb_iob_cache_line_fill_buffer.sv
// Directed bench for the line-fill buffer: 4 beats of 64 bits, 32-bit words.
module tb_iob_cache_line_fill_buffer;

`ifdef IOB_CACHE_LFB_CRIT_WORD_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned nchk = 0;
  int unsigned nerr = 0;

  iob_cache_line_fill_buffer_if #(
    .ADDR_W(32), .DATA_W(32), .BE_DATA_W(64), .WORD_OFFSET_W(3)
  ) bus ();

  iob_cache_line_fill_buffer #(
    .ADDR_W(32), .DATA_W(32), .BE_DATA_W(64), .WORD_OFFSET_W(3)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic        mv;
    logic [29:0] ma;
    logic        rep;
    logic        rdv;
    logic [1:0]  ra;
    logic [63:0] rd;
    logic        e_rdy, e_rv, e_we, e_crit, e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] bt(input logic [7:0] tag);
    return {tag, 24'h111111, tag, 24'h000000};
  endfunction

  function automatic vec_t mk(input int mv, input int ma, input int rep, input int rdv,
                              input int ra, input logic [63:0] rd, input int rdy,
                              input int rv, input int we, input int crit, input int err);
    vec_t v;
    v.mv = (mv != 0);  v.ma = 30'(ma);  v.rep = (rep != 0);  v.rdv = (rdv != 0);
    v.ra = 2'(ra);     v.rd = rd;
    v.e_rdy = (rdy != 0); v.e_rv = (rv != 0); v.e_we = (we != 0);
    v.e_crit = (crit != 0); v.e_err = (err != 0);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.miss_valid_i = v.mv;
    bus.miss_addr_i  = v.ma;
    bus.replace_i    = v.rep;
    bus.read_valid_i = v.rdv;
    bus.read_addr_i  = v.ra;
    bus.read_rdata_i = v.rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string name, input logic [26:0] raddr,
                           input logic [255:0] eline, input logic [31:0] ecrit);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("%s[%0d].miss_ready", name, i), 256'(bus.miss_ready_o), 256'(tbl[i].e_rdy));
      chk($sformatf("%s[%0d].replace_valid", name, i), 256'(bus.replace_valid_o), 256'(tbl[i].e_rv));
      chk($sformatf("%s[%0d].line_we", name, i), 256'(bus.line_we_o), 256'(tbl[i].e_we));
      chk($sformatf("%s[%0d].crit_valid", name, i), 256'(bus.crit_valid_o), 256'(tbl[i].e_crit));
      chk($sformatf("%s[%0d].fill_err", name, i), 256'(bus.fill_err_o), 256'(tbl[i].e_err));
      if (tbl[i].e_rv)
        chk($sformatf("%s[%0d].replace_addr", name, i), 256'(bus.replace_addr_o), 256'(raddr));
      if (tbl[i].e_we) begin
        chk($sformatf("%s[%0d].line_wdata", name, i), bus.line_wdata_o, eline);
        chk($sformatf("%s[%0d].line_addr", name, i), 256'(bus.line_addr_o), 256'(raddr));
      end
      if (tbl[i].e_crit)
        chk($sformatf("%s[%0d].crit_rdata", name, i), 256'(bus.crit_rdata_o), 256'(ecrit));
      next_cycle();
    end
  endtask

  // Miss word 0x1005: line 0x200, word offset 5 -> beat 2, upper half.
  task automatic fill_inorder();
    tbl.delete();
    tbl.push_back(mk(1, 'h1005, 0, 0, 0, 64'h0,      1, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,      0, 0, 0, 64'h0,      0, 1, 0, 0,   0));
    tbl.push_back(mk(0, 0,      1, 0, 0, 64'h0,      0, 1, 0, 0,   0));
    tbl.push_back(mk(0, 0,      1, 1, 0, bt(8'hA0),  0, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,      1, 1, 1, bt(8'hA1),  0, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,      1, 1, 2, bt(8'hA2),  0, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,      1, 1, 3, bt(8'hA3),  0, 0, 0, CE,  0));
    tbl.push_back(mk(0, 0,      0, 0, 0, 64'h0,      0, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,      0, 0, 0, 64'h0,      0, 0, 1, !CE, 0));
    tbl.push_back(mk(0, 0,      0, 0, 0, 64'h0,      1, 0, 0, 0,   0));
  endtask

  logic [255:0] line_a;
  logic [255:0] line_c;

  initial begin
    line_a = {bt(8'hA3), bt(8'hA2), bt(8'hA1), bt(8'hA0)};
    line_c = {bt(8'hC3), bt(8'hC2), bt(8'hC1), bt(8'hC0)};

    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0));
    repeat (2) next_cycle();
    @(negedge clk);
    chk("reset.miss_ready", 256'(bus.miss_ready_o), 256'(1));
    chk("reset.replace_valid", 256'(bus.replace_valid_o), 256'(0));
    chk("reset.line_we", 256'(bus.line_we_o), 256'(0));
    chk("reset.crit_valid", 256'(bus.crit_valid_o), 256'(0));
    chk("reset.fill_err", 256'(bus.fill_err_o), 256'(0));
    chk("reset.line_wdata", bus.line_wdata_o, 256'(0));
    chk("reset.crit_rdata", 256'(bus.crit_rdata_o), 256'(0));
    next_cycle();
    rst_n = 1'b1;

    fill_inorder();
    run_table("inorder", 27'h200, line_a, 32'hA2111111);

    // Miss word 0x2A3: line 0x54, offset 3 -> beat 1, upper half; full retry pass.
    tbl.delete();
    tbl.push_back(mk(1, 'h2A3, 0, 0, 0, 64'h0,     1, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 64'h0,     0, 1, 0, 0,   0));
    tbl.push_back(mk(0, 0,     1, 0, 0, 64'h0,     0, 1, 0, 0,   0));
    tbl.push_back(mk(0, 0,     1, 1, 0, bt(8'hB0), 0, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,     1, 1, 1, bt(8'hB1), 0, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,     1, 1, 2, bt(8'hB2), 0, 0, 0, CE,  0));
    tbl.push_back(mk(0, 0,     1, 1, 3, bt(8'hB3), 0, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,     1, 1, 0, bt(8'hC0), 0, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,     1, 1, 1, bt(8'hC1), 0, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,     1, 1, 2, bt(8'hC2), 0, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,     1, 1, 3, bt(8'hC3), 0, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 64'h0,     0, 0, 0, 0,   0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 64'h0,     0, 0, 1, !CE, 0));
    tbl.push_back(mk(0, 0,     0, 0, 0, 64'h0,     1, 0, 0, 0,   0));
    run_table("retry", 27'h54, line_c, CE ? 32'hB1111111 : 32'hC1111111);

    // Beat 2 missing; a beat offered during REQ must not count toward the mask.
    tbl.delete();
    tbl.push_back(mk(1, 'h1005, 0, 0, 0, 64'h0,     1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,      0, 0, 0, 64'h0,     0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0,      1, 1, 2, bt(8'hEE), 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0,      1, 1, 0, bt(8'hD0), 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,      1, 1, 1, bt(8'hD1), 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,      1, 1, 3, bt(8'hD3), 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,      0, 0, 0, 64'h0,     0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,      0, 0, 0, 64'h0,     0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0,      0, 0, 0, 64'h0,     1, 0, 0, 0, 0));
    run_table("missing", 27'h200, 256'h0, 32'h0);

    // Back-pressure in REQ, with a competing miss that must be refused.
    drive(mk(1, 'h3FF8, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0));
    next_cycle();
    drive(mk(1, 'h1234, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp[%0d].replace_valid", i), 256'(bus.replace_valid_o), 256'(1));
      chk($sformatf("bp[%0d].replace_addr", i), 256'(bus.replace_addr_o), 256'(27'h7FF));
      chk($sformatf("bp[%0d].miss_ready", i), 256'(bus.miss_ready_o), 256'(0));
      next_cycle();
    end
    drive(mk(0, 0, 1, 0, 0, 64'h0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("bp.grant.replace_valid", 256'(bus.replace_valid_o), 256'(1));
    next_cycle();
    drive(mk(0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("bp.fill.replace_valid", 256'(bus.replace_valid_o), 256'(0));
    next_cycle();
    @(negedge clk);
    chk("bp.commit.fill_err", 256'(bus.fill_err_o), 256'(1));
    chk("bp.commit.line_we", 256'(bus.line_we_o), 256'(0));
    chk("bp.commit.line_addr", 256'(bus.line_addr_o), 256'(27'h7FF));
    next_cycle();
    @(negedge clk);
    chk("bp.idle.miss_ready", 256'(bus.miss_ready_o), 256'(1));

    // Reset after beat 1, while the critical beat is being offered.
    drive(mk(1, 'h1005, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0));
    next_cycle();
    drive(mk(0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0));
    next_cycle();
    drive(mk(0, 0, 1, 0, 0, 64'h0, 0, 0, 0, 0, 0));
    next_cycle();
    drive(mk(0, 0, 1, 1, 0, bt(8'hF0), 0, 0, 0, 0, 0));
    next_cycle();
    drive(mk(0, 0, 1, 1, 1, bt(8'hF1), 0, 0, 0, 0, 0));
    next_cycle();
    rst_n = 1'b0;
    drive(mk(0, 0, 1, 1, 2, bt(8'hF2), 0, 0, 0, 0, 0));
    next_cycle();
    rst_n = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst[%0d].miss_ready", i), 256'(bus.miss_ready_o), 256'(1));
      chk($sformatf("rst[%0d].line_we", i), 256'(bus.line_we_o), 256'(0));
      chk($sformatf("rst[%0d].crit_valid", i), 256'(bus.crit_valid_o), 256'(0));
      chk($sformatf("rst[%0d].fill_err", i), 256'(bus.fill_err_o), 256'(0));
      next_cycle();
    end

    fill_inorder();
    run_table("post_reset", 27'h200, line_a, 32'hA2111111);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
